bios_wdt_ctrl: RTL and testbench

Watchdog controller consuming the five toggle-encoded BIOS WDT write events (0x55, 0x29, 0xFF, 0xAA, other) already re-timed into the CLK32768 domain. Sequences arm / kick / disable commands, runs the seconds countdown, and on expiry issues a platform reset request and flips the active BIOS flash select. Sits between the WDT write decoder and the reset/BIOS-select logic in the top level.

---
 rtl/bios_wdt_ctrl_if.sv | 23 ++
 rtl/bios_wdt_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_bios_wdt_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/bios_wdt_ctrl_if.sv
// Bus between the WDT write decoder / reset logic and the BIOS watchdog
// controller. The master side drives the toggle events and the board strap;
// the slave side (the controller) returns reset request and status.
interface bios_wdt_ctrl_if;
    logic [4:0] bCPUWrWdtRegSig;
    logic       WdtEnable;
    logic       WdtRstReqN;
    logic       BiosSel;
    logic       WdtActive;
    logic       WdtExpired;
    logic [1:0] WdtFailCnt;
    logic [7:0] WdtSecLeft;

    modport master (
        output bCPUWrWdtRegSig, WdtEnable,
        input  WdtRstReqN, BiosSel, WdtActive, WdtExpired, WdtFailCnt, WdtSecLeft
    );

    modport slave (
        input  bCPUWrWdtRegSig, WdtEnable,
        output WdtRstReqN, BiosSel, WdtActive, WdtExpired, WdtFailCnt, WdtSecLeft
    );
endinterface

// File: rtl/bios_wdt_ctrl.sv
// BIOS watchdog controller. Turns toggle-encoded WDT register writes into
// arm / kick / disable commands, counts down whole seconds, and on expiry
// pulses a platform reset request and swaps the active BIOS flash.
module bios_wdt_ctrl #(
    parameter int PRESCALE    = 32768,  // CLK32768 cycles per second tick
    parameter int TIMEOUT_SEC = 180,    // seconds loaded on arm / kick
    parameter int KICK_WIN    = 328,    // max cycles between 0x55 and 0xAA
    parameter int RST_PULSE   = 33      // low time of WdtRstReqN
) (
    input  logic           MainResetN,
    input  logic           CLK32768,
    bios_wdt_ctrl_if.slave wdt
);

    localparam int PW = $clog2(PRESCALE);
    localparam int KW = $clog2(KICK_WIN + 1);
    localparam int RW = $clog2(RST_PULSE + 1);

    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESCALE - 1);
    localparam logic [KW-1:0] WIN_LAST   = KW'(KICK_WIN - 1);
    localparam logic [RW-1:0] PULSE_LAST = RW'(RST_PULSE - 1);
    localparam logic [7:0]    SEC_LOAD   = 8'(TIMEOUT_SEC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_KICK1,
        ST_EXPIRE
    } state_e;

    // One decoded command per cycle; simultaneous writes collapse to this.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_OTHER,   // any other value written
        CMD_DIS,     // 0xFF
        CMD_ARM,     // 0x29
        CMD_K55,     // 0x55, first half of kick
        CMD_KAA      // 0xAA, second half of kick
    } cmd_e;

    state_e          r_state;
    logic [4:0]      r_prev;
    logic [PW-1:0]   r_presc;
    logic [KW-1:0]   r_win;
    logic [RW-1:0]   r_pulse;
    logic            r_rst_n;
    logic            r_bios;
    logic            r_active;
    logic            r_expired;
    logic [1:0]      r_fail;
    logic [7:0]      r_sec;

    logic [4:0]      w_ev;
    cmd_e            w_cmd;
    logic            w_wrap;
    logic            w_last_sec;

    assign w_ev       = wdt.bCPUWrWdtRegSig ^ r_prev;
    assign w_wrap     = (r_presc == PRESC_LAST);
    assign w_last_sec = (r_sec == 8'd1);

    // Priority-encode the toggle events: other > 0xFF > 0x29 > 0x55 > 0xAA.
    always_comb begin
        w_cmd = CMD_NONE;
        if (w_ev[4])      w_cmd = CMD_OTHER;
        else if (w_ev[2]) w_cmd = CMD_DIS;
        else if (w_ev[1]) w_cmd = CMD_ARM;
        else if (w_ev[0]) w_cmd = CMD_K55;
        else if (w_ev[3]) w_cmd = CMD_KAA;
    end

    // Watchdog sequencer: command handling, countdown, expiry pulse.
    always_ff @(posedge CLK32768 or negedge MainResetN) begin
        if (!MainResetN) begin
            r_state   <= ST_IDLE;
            r_prev    <= '0;
            r_presc   <= '0;
            r_win     <= '0;
            r_pulse   <= '0;
            r_rst_n   <= 1'b1;
            r_bios    <= 1'b0;
            r_active  <= 1'b0;
            r_expired <= 1'b0;
            r_fail    <= '0;
            r_sec     <= '0;
        end else begin
            r_prev <= wdt.bCPUWrWdtRegSig;

            case (r_state)
                ST_IDLE: begin
                    if (wdt.WdtEnable && w_cmd == CMD_ARM) begin
                        r_state  <= ST_ARMED;
                        r_active <= 1'b1;
                        r_sec    <= SEC_LOAD;
                        r_presc  <= '0;
                    end
                end

                ST_ARMED, ST_KICK1: begin
                    if (!wdt.WdtEnable) begin
                        r_state  <= ST_IDLE;
                        r_active <= 1'b0;
                        r_sec    <= '0;
                    end else if (w_wrap && w_last_sec) begin
                        // Expiry outranks any command seen on the same edge.
                        r_state   <= ST_EXPIRE;
                        r_active  <= 1'b0;
                        r_rst_n   <= 1'b0;
                        r_bios    <= ~r_bios;
                        r_expired <= 1'b1;
                        if (r_fail != 2'd3) r_fail <= r_fail + 2'd1;
                        r_sec     <= '0;
                        r_pulse   <= '0;
                    end else begin
                        // NOTE: the countdown is the default; a reload or
                        // disable below assigns the same registers later in
                        // this block and the last non-blocking write wins.
                        r_presc <= w_wrap ? '0 : r_presc + 1'b1;
                        if (w_wrap) r_sec <= r_sec - 8'd1;

                        if (r_state == ST_ARMED) begin
                            case (w_cmd)
                                CMD_DIS: begin
                                    r_state  <= ST_IDLE;
                                    r_active <= 1'b0;
                                    r_sec    <= '0;
                                end
                                CMD_ARM: begin
                                    r_sec   <= SEC_LOAD;
                                    r_presc <= '0;
                                end
                                CMD_K55: begin
                                    r_state <= ST_KICK1;
                                    r_win   <= '0;
                                end
                                default: ;
                            endcase
                        end else begin
                            case (w_cmd)
                                CMD_KAA: begin
                                    r_state <= ST_ARMED;
                                    r_sec   <= SEC_LOAD;
                                    r_presc <= '0;
                                end
                                CMD_DIS: begin
                                    r_state  <= ST_IDLE;
                                    r_active <= 1'b0;
                                    r_sec    <= '0;
                                end
                                CMD_OTHER, CMD_K55, CMD_ARM: begin
                                    // Broken sequence: back to ARMED, no reload.
                                    r_state <= ST_ARMED;
                                end
                                default: begin
                                    if (r_win == WIN_LAST) r_state <= ST_ARMED;
                                    else                   r_win   <= r_win + 1'b1;
                                end
                            endcase
                        end
                    end
                end

                ST_EXPIRE: begin
                    // Pulse always completes, even if the strap drops.
                    if (r_pulse == PULSE_LAST) begin
                        r_rst_n <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_pulse <= r_pulse + 1'b1;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign wdt.WdtRstReqN = r_rst_n;
    assign wdt.BiosSel    = r_bios;
    assign wdt.WdtActive  = r_active;
    assign wdt.WdtExpired = r_expired;
    assign wdt.WdtFailCnt = r_fail;
    assign wdt.WdtSecLeft = r_sec;

endmodule

// File: tb/tb_bios_wdt_ctrl.sv
// Bench for bios_wdt_ctrl. Stimulus tasks push timed expectations onto a
// scoreboard queue; a negedge monitor pops entries due in the current cycle
// and compares them against the DUT outputs.
module tb_bios_wdt_ctrl;

    localparam int P     = 16;  // PRESCALE
    localparam int T     = 3;   // TIMEOUT_SEC
    localparam int W     = 8;   // KICK_WIN
    localparam int R     = 6;   // RST_PULSE
    localparam int TO_CY = P * T;

    typedef enum int {F_RSTN, F_BIOS, F_ACT, F_EXP, F_CNT, F_SEC} fld_e;

    typedef struct {
        int    cyc;
        fld_e  fld;
        int    val;
        string tag;
    } exp_t;

    logic MainResetN;
    logic CLK32768;
    int   cyc;
    int   n_checks;
    int   n_fail;
    int   exp_bios;
    int   exp_cnt;
    exp_t sb[$];

    bios_wdt_ctrl_if wdt_if ();

    bios_wdt_ctrl #(
        .PRESCALE    (P),
        .TIMEOUT_SEC (T),
        .KICK_WIN    (W),
        .RST_PULSE   (R)
    ) dut (
        .MainResetN (MainResetN),
        .CLK32768   (CLK32768),
        .wdt        (wdt_if)
    );

    initial CLK32768 = 1'b0;
    always #10 CLK32768 = ~CLK32768;

    initial cyc = 0;
    always @(posedge CLK32768) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", tag, cyc, act, exp);
        end
    endtask

    function automatic logic [31:0] get_field(input fld_e f);
        case (f)
            F_RSTN:  return 32'(wdt_if.WdtRstReqN);
            F_BIOS:  return 32'(wdt_if.BiosSel);
            F_ACT:   return 32'(wdt_if.WdtActive);
            F_EXP:   return 32'(wdt_if.WdtExpired);
            F_CNT:   return 32'(wdt_if.WdtFailCnt);
            default: return 32'(wdt_if.WdtSecLeft);
        endcase
    endfunction

    // Scoreboard monitor: compare every expectation due this cycle.
    always @(negedge CLK32768) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                check(sb[i].tag, get_field(sb[i].fld), sb[i].val);
                sb.delete(i);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK32768);
    endtask

    task automatic expect_at(input int off, input fld_e f, input int v, input string tag);
        sb.push_back('{cyc + off, f, v, tag});
    endtask

    task automatic toggle(input logic [4:0] mask);
        wdt_if.bCPUWrWdtRegSig = wdt_if.bCPUWrWdtRegSig ^ mask;
    endtask

    task automatic check_reset_all(input string tag);
        check({tag, "_rstn"}, 32'(wdt_if.WdtRstReqN), 1);
        check({tag, "_bios"}, 32'(wdt_if.BiosSel),    0);
        check({tag, "_act"},  32'(wdt_if.WdtActive),  0);
        check({tag, "_exp"},  32'(wdt_if.WdtExpired), 0);
        check({tag, "_cnt"},  32'(wdt_if.WdtFailCnt), 0);
        check({tag, "_sec"},  32'(wdt_if.WdtSecLeft), 0);
    endtask

    // Expected expiry at offset off: entry values, plus pulse end if asked.
    task automatic push_expiry(input int off, input string tag, input bit with_end);
        expect_at(off - 1, F_RSTN, 1, {tag, "_pre_rstn"});
        expect_at(off - 1, F_BIOS, exp_bios, {tag, "_pre_bios"});
        exp_bios = 1 - exp_bios;
        exp_cnt  = (exp_cnt < 3) ? exp_cnt + 1 : 3;
        expect_at(off, F_RSTN, 0,        {tag, "_rstn_low"});
        expect_at(off, F_BIOS, exp_bios, {tag, "_bios"});
        expect_at(off, F_EXP,  1,        {tag, "_expired"});
        expect_at(off, F_CNT,  exp_cnt,  {tag, "_failcnt"});
        expect_at(off, F_SEC,  0,        {tag, "_sec"});
        expect_at(off, F_ACT,  0,        {tag, "_act"});
        if (with_end) begin
            expect_at(off + R - 1, F_RSTN, 0, {tag, "_pulse_last"});
            expect_at(off + R,     F_RSTN, 1, {tag, "_pulse_end"});
        end
    endtask

    // Arm, never kick, let it expire; poke 0x29 during the pulse.
    task automatic run_expiry(input string tag);
        toggle(5'b00010);
        expect_at(1, F_ACT, 1, {tag, "_arm_act"});
        expect_at(1, F_SEC, T, {tag, "_arm_sec"});
        expect_at(1, F_EXP, (exp_cnt > 0) ? 1 : 0, {tag, "_arm_expired"});
        expect_at(P,     F_SEC, T,     {tag, "_sec_pre_tick"});
        expect_at(P + 1, F_SEC, T - 1, {tag, "_sec_tick"});
        push_expiry(1 + TO_CY, tag, 1'b1);
        tick(TO_CY + 3);
        toggle(5'b00010);
        expect_at(1, F_ACT, 0, {tag, "_pulse_ignore_act"});
        expect_at(1, F_SEC, 0, {tag, "_pulse_ignore_sec"});
        expect_at(R, F_ACT, 0, {tag, "_idle_after"});
        tick(R + 4);
    endtask

    initial begin
        #200000;
        $display("FAIL tb_timeout: run did not finish, got time %0t, limit 200000", $time);
        $fatal(1, "time limit exceeded");
    end

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_bios = 0;
        exp_cnt  = 0;
        MainResetN = 1'b0;
        wdt_if.bCPUWrWdtRegSig = '0;
        wdt_if.WdtEnable = 1'b1;
        tick(3);
        check_reset_all("por");
        MainResetN = 1'b1;
        tick(2);

        // Expiry 1: plain arm-and-wait.
        run_expiry("exp1");

        // Full kick while one second is left; no expiry on the old schedule.
        toggle(5'b00010);
        tick(32);
        toggle(5'b00001);
        expect_at(1, F_ACT, 1, "kick_k1_act");
        expect_at(1, F_SEC, 1, "kick_k1_sec");
        tick(5);
        toggle(5'b01000);
        expect_at(1,  F_SEC,  3, "kick_reload");
        expect_at(12, F_RSTN, 1, "kick_no_expiry");
        expect_at(12, F_SEC,  3, "kick_sec_hold");
        expect_at(16, F_SEC,  3, "kick_presc_pre");
        expect_at(17, F_SEC,  2, "kick_presc_zeroed");
        tick(20);
        // Disable and arm on the same edge: disable wins.
        toggle(5'b00110);
        expect_at(1,  F_ACT,  0, "dis_prio_act");
        expect_at(1,  F_SEC,  0, "dis_prio_sec");
        expect_at(10, F_RSTN, 1, "dis_prio_no_rst");
        expect_at(10, F_ACT,  0, "dis_prio_stays_idle");
        tick(12);

        // Expiry 2: 0x55 then window timeout, late 0xAA ignored.
        toggle(5'b00010);
        tick(4);
        toggle(5'b00001);
        expect_at(1, F_ACT, 1, "win_k1_act");
        tick(9);
        toggle(5'b01000);
        expect_at(1, F_SEC, 3, "win_late_aa_sec");
        expect_at(4, F_SEC, 2, "win_no_reload");
        push_expiry(36, "exp2", 1'b1);
        tick(36 + R + 3);

        // Expiries 3 and 4: fail count saturates, BIOS select keeps flipping.
        run_expiry("exp3");
        run_expiry("exp4");

        // Strap dropped while armed, then arm attempt while disabled.
        toggle(5'b00010);
        tick(4);
        wdt_if.WdtEnable = 1'b0;
        expect_at(1, F_ACT, 0, "strap_idle_act");
        expect_at(1, F_SEC, 0, "strap_idle_sec");
        tick(2);
        toggle(5'b00010);
        expect_at(1, F_ACT, 0, "strap_no_arm_act");
        expect_at(1, F_SEC, 0, "strap_no_arm_sec");
        expect_at(3, F_ACT, 0, "strap_no_arm_late");
        tick(4);
        wdt_if.WdtEnable = 1'b1;
        expect_at(2, F_ACT, 0, "strap_reenable_idle");
        tick(4);

        // Reset in the middle of the expiry pulse.
        toggle(5'b00010);
        push_expiry(1 + TO_CY, "exp5", 1'b0);
        expect_at(TO_CY + 2, F_RSTN, 0, "exp5_mid_pulse");
        tick(TO_CY + 2);
        #2;
        MainResetN = 1'b0;
        wdt_if.bCPUWrWdtRegSig = '0;
        #1;
        check_reset_all("midpulse");
        exp_bios = 0;
        exp_cnt  = 0;
        tick(2);
        MainResetN = 1'b1;
        expect_at(2, F_ACT,  0, "post_rst_act");
        expect_at(2, F_RSTN, 1, "post_rst_rstn");
        tick(4);

        check("sb_drained", 32'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
